// File: rtl/stage3_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the execute stage: 32-cycle shift-add / restoring divide.
// Optional macro STAGE3_MULDIV_FAST_MUL_EN computes all MUL* ops combinationally in one cycle.
module stage3_muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic        FLUSH,
    output logic [31:0] RESULT,
    output logic        DONE,
    output logic        BUSY,
    output logic        STALL
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        is_div, sign_a, sign_b, neg_a, neg_b;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, div_ovf, early, accept;
    logic [31:0] early_res;
    logic        fast_hit;
    logic [31:0] fast_res;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] prod;
    logic [31:0] quo, remv;

    // Operand decode: MULH/DIV/REM are fully signed, MULHSU treats only DATA1 as signed.
    assign is_div   = FUNCT3[2];
    assign sign_a   = is_div ? ~FUNCT3[0] : (FUNCT3[1:0] == 2'b01 || FUNCT3[1:0] == 2'b10);
    assign sign_b   = is_div ? ~FUNCT3[0] : (FUNCT3[1:0] == 2'b01);
    assign neg_a    = sign_a & DATA1[31];
    assign neg_b    = sign_b & DATA2[31];
    assign abs_a    = neg_a ? (32'd0 - DATA1) : DATA1;
    assign abs_b    = neg_b ? (32'd0 - DATA2) : DATA2;
    assign div_zero = is_div & (DATA2 == 32'd0);
    assign div_ovf  = is_div & ~FUNCT3[0] & (DATA1 == 32'h8000_0000) & (DATA2 == 32'hFFFF_FFFF);
    assign early_res = div_zero ? (FUNCT3[1] ? DATA1 : 32'hFFFF_FFFF)
                                : (FUNCT3[1] ? 32'd0 : 32'h8000_0000);

`ifdef STAGE3_MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_prod;
    assign fast_prod = $signed({neg_a, DATA1}) * $signed({neg_b, DATA2});
    assign fast_hit  = ~is_div;
    assign fast_res  = (FUNCT3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = 32'd0;
`endif

    assign early  = div_zero | div_ovf | fast_hit;
    assign accept = START & ~FLUSH & (state_q == S_IDLE);

    // Multiply: accumulator = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide: accumulator = {remainder, dividend/quotient}, shifted left each step.
    assign div_trial = acc_q[63:31] - {1'b0, opb_q};
    assign prod      = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign quo       = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign remv      = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = early ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (FLUSH) state_d = S_IDLE;
    end

    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d      = FUNCT3;
                cnt_d     = 5'd0;
                neg_res_d = neg_a ^ neg_b;
                neg_rem_d = neg_a;
                acc_d     = {32'd0, is_div ? abs_a : abs_b};
                opb_d     = is_div ? abs_b : abs_a;
                if (early) result_d = is_div ? early_res : fast_res;
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[2])
                    acc_d = {div_trial[32] ? acc_q[62:31] : div_trial[31:0], acc_q[30:0], ~div_trial[32]};
                else
                    acc_d = {mul_sum, acc_q[31:1]};
            end
            S_FIX: if (!FLUSH) begin
                if (op_q[2])                result_d = op_q[1] ? remv : quo;
                else if (op_q[1:0] == 2'b00) result_d = prod[31:0];
                else                        result_d = prod[63:32];
            end
            default: ;
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_q      <= 3'd0;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        RESULT = result_q;
        DONE   = done_q;
        BUSY   = busy_q;
        STALL  = (START & (state_q == S_IDLE) & ~FLUSH & ~early) | busy_q;
    end
endmodule

// File: doc/stage3_muldiv_unit.md
# stage3_muldiv_unit

Iterative RV32M multiply/divide engine in the execute stage (stage 3), directly downstream of the stage-3 operand forwarding muxes. It consumes the already-forwarded operands DATA1/DATA2 and the instruction's funct3. It runs a shift-based multi-cycle computation and hands a 32-bit result to the stage-3/4 pipeline register. While it is occupied, it drives a stall request to the hazard logic so that the forwarding selects and operands stay frozen.

## Interface
- Parameters: none; datapath fixed at 32 bits, iteration count fixed at 32.
- CLK  input  1  pipeline clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  M-extension instruction present in stage 3; sampled only in IDLE.
- FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  32  forwarded rs1 operand.
- DATA2  input  32  forwarded rs2 operand.
- FLUSH  input  1  kill the in-flight operation (branch redirect).
- RESULT  output  32  registered result; holds last value until the next completion.
- DONE  output  1  registered; high for exactly one cycle when RESULT is newly valid.
- BUSY  output  1  registered; high while state is CALC or FIX.
- STALL  output  1  combinational: (START & IDLE & ~FLUSH & ~early-out) | BUSY.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On START & ~FLUSH, latch FUNCT3 and operands and compute sign flags.
  - Signed ops (MULH, DIV, REM; DATA1 only for MULHSU) use absolute values.
  - Go to CALC with the 5-bit counter at 0.
- Early-outs (IDLE → DONE directly, no CALC):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC:
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: radix-2 restoring, one quotient bit per cycle; 33-bit trial subtract of the remainder register and divisor.
  - Counter increments each cycle; after iteration 31 → FIX.
- FIX:
  - Negate the 64-bit product if operand signs differ.
  - Negate the quotient if dividend and divisor signs differ (signed divides).
  - Remainder takes the sign of the dividend.
  - Select low word (MUL), high word (MULH/MULHSU/MULHU), quotient, or remainder into RESULT → DONE.
- DONE: DONE=1 for one cycle → IDLE. A START in that same cycle is ignored; the hazard logic reissues it.
- START in CALC/FIX: ignored.
- FLUSH in any state: next edge → IDLE with DONE=0 and RESULT unchanged. FLUSH beats a simultaneous START.
- Reset (any time, including mid-operation): state IDLE, RESULT=0, DONE=0, BUSY=0, counter=0, internal accumulators=0.

## Timing
- START high in cycle N (IDLE):
  - CALC occupies cycles N+1..N+32.
  - FIX occupies cycle N+33.
  - DONE=1 and RESULT valid in cycle N+34.
- BUSY high cycles N+1..N+33. STALL high cycles N..N+33 and low in N+34, so the dependent instruction advances with RESULT.
- Early-out: DONE=1 in cycle N+1; STALL low in cycle N.
- Back-to-back operations: the next START is accepted no earlier than cycle N+35.

## Configuration
- STAGE3_MULDIV_FAST_MUL_EN defined:
  - All MUL* ops are computed combinationally from the IDLE operands with a 64-bit signed/unsigned multiply.
  - Result registered IDLE → DONE; DONE in cycle N+1, no stall beyond cycle N.
  - Divides are unchanged.
- Undefined: multiplies use the 32-iteration CALC path described above.

## Test plan
- MUL 7 × (−3) (0x00000007, 0xFFFFFFFD) → RESULT 0xFFFFFFEB, DONE in cycle N+34 (N+1 with fast-mul macro).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH of the same operands → 0x00000000; MULHSU → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14, REMU 100/7 → 2. For each: BUSY high 33 cycles.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/−1 → 0x80000000, REM → 0. For each: DONE in cycle N+1, BUSY never high.
- FLUSH asserted at CALC cycle 10 → IDLE next cycle, DONE stays 0, RESULT keeps its previous value; a new DIVU 9/3 then returns 3.
- RESET low at CALC cycle 20 → all outputs 0 immediately. After release, START is ignored during CALC and a fresh op completes correctly.
